// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT datapath: frame geometry, sequencer states
// and the slot-slicing helper for packed N*DW buses.
`ifndef FFT_SLICE
`define FFT_SLICE(k, w) ((k)*(w)) +: (w)
`endif

package fft_pkg;

  localparam int FFT_N  = 16;
  localparam int FFT_DW = 16;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } fft_state_e;

endpackage

// File: rtl/fft16_frame_buf.sv
// N-entry complex register file: single-slot write port, whole-frame parallel load,
// and the full frame always visible on the parallel read bus.
module fft16_frame_buf
  import fft_pkg::*;
#(
  parameter int DW = FFT_DW,
  parameter int N  = FFT_N
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [$clog2(N)-1:0]   waddr,
  input  logic signed [DW-1:0]   wr_re,
  input  logic signed [DW-1:0]   wr_im,
  input  logic                   ld,
  input  logic [N*DW-1:0]        ld_re,
  input  logic [N*DW-1:0]        ld_im,
  output logic [N*DW-1:0]        rd_re,
  output logic [N*DW-1:0]        rd_im
);

  // Data storage only; contents survive reset and are simply overwritten.
  always_ff @(posedge clk) begin
    if (ld) begin
      rd_re <= ld_re;
      rd_im <= ld_im;
    end else if (we) begin
      rd_re[`FFT_SLICE(waddr, DW)] <= wr_re;
      rd_im[`FFT_SLICE(waddr, DW)] <= wr_im;
    end
  end

endmodule

// File: rtl/fft16_stage1_ctrl.sv
// Sequencer around the radix-4 first-stage butterfly: serial frame in, parallel
// compute with latency wait, serial frame out under valid/ready.
module fft16_stage1_ctrl
  import fft_pkg::*;
#(
  parameter int DW       = FFT_DW,
  parameter int N        = FFT_N,
  parameter int BFLY_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic                 in_last,
  output logic [N*DW-1:0]      bf_re_in,
  output logic [N*DW-1:0]      bf_im_in,
  output logic                 bf_en,
  input  logic [N*DW-1:0]      bf_re_out,
  input  logic [N*DW-1:0]      bf_im_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 out_last,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int               IW       = $clog2(N);
  localparam int               LAT_W    = $clog2(BFLY_LAT + 1);
  localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);
  localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(BFLY_LAT);

  fft_state_e       state;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] lat_nxt;
  logic             in_fire;
  logic             slot_last;
  logic             in_we;
  logic             res_ld;
  logic             out_fire;
  logic [N*DW-1:0]  res_re;
  logic [N*DW-1:0]  res_im;

  // A sample is kept only when in_last agrees with its slot position.
  assign in_fire   = in_valid && in_ready;
  assign slot_last = (wr_idx == LAST_IDX);
  assign in_we     = in_fire && (in_last == slot_last);
  assign lat_nxt   = lat_cnt + 1'b1;
  assign res_ld    = (state == ST_COMPUTE) && (lat_cnt == LAT_END);
  assign out_fire  = out_valid && out_ready;

  fft16_frame_buf #(.DW(DW), .N(N)) u_in_buf (
    .clk   (clk),
    .we    (in_we),
    .waddr (wr_idx),
    .wr_re (in_re),
    .wr_im (in_im),
    .ld    (1'b0),
    .ld_re ('0),
    .ld_im ('0),
    .rd_re (bf_re_in),
    .rd_im (bf_im_in)
  );

  fft16_frame_buf #(.DW(DW), .N(N)) u_res_buf (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wr_re ('0),
    .wr_im ('0),
    .ld    (res_ld),
    .ld_re (bf_re_out),
    .ld_im (bf_im_out),
    .rd_re (res_re),
    .rd_im (res_im)
  );

  // Output data comes straight from the result register file, zeroed when idle.
  assign out_re = out_valid ? $signed(res_re[`FFT_SLICE(rd_idx, DW)]) : '0;
  assign out_im = out_valid ? $signed(res_im[`FFT_SLICE(rd_idx, DW)]) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      wr_idx    <= '0;
      rd_idx    <= '0;
      lat_cnt   <= '0;
      in_ready  <= 1'b0;
      bf_en     <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_LOAD: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            if (in_we && slot_last) begin
              wr_idx   <= '0;
              lat_cnt  <= '0;
              in_ready <= 1'b0;
              bf_en    <= 1'b1;
              busy     <= 1'b1;
              state    <= ST_COMPUTE;
            end else if (in_we) begin
              wr_idx <= wr_idx + 1'b1;
            end else begin
              wr_idx    <= '0;
              frame_err <= 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          // bf_en covers the BFLY_LAT cycles the butterfly consumes its inputs;
          // the final COMPUTE cycle only captures the settled results.
          if (res_ld) begin
            lat_cnt   <= '0;
            rd_idx    <= '0;
            bf_en     <= 1'b0;
            out_valid <= 1'b1;
            out_last  <= (LAST_IDX == '0);
            state     <= ST_DRAIN;
          end else begin
            lat_cnt <= lat_nxt;
            bf_en   <= (lat_nxt != LAT_END);
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= ST_LOAD;
            end else begin
              rd_idx   <= rd_idx + 1'b1;
              out_last <= (rd_idx + 1'b1 == LAST_IDX);
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft16_stage1_ctrl.sv
// Bench for fft16_stage1_ctrl: identity butterfly model, frame-level reference model
// and an output scoreboard under directed and randomized traffic.
module tb_fft16_stage1_ctrl;

  localparam int DW       = 16;
  localparam int N        = 16;
  localparam int BFLY_LAT = 1;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic                 last;
  } smp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 in_last;
  logic [N*DW-1:0]      bf_re_in;
  logic [N*DW-1:0]      bf_im_in;
  logic                 bf_en;
  logic [N*DW-1:0]      bfo_re;
  logic [N*DW-1:0]      bfo_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic                 out_last;
  logic                 busy;
  logic                 frame_err;

  int n_checks = 0;
  int n_errs   = 0;

  smp_t                 exp_q[$];
  logic signed [DW-1:0] fr_re[N];
  logic signed [DW-1:0] fr_im[N];
  int                   mcnt      = 0;
  int                   frame_pos = 0;
  int                   rdy_mode  = 0;
  int                   pat_i     = 0;

  logic                 stall_prev = 1'b0;
  logic signed [DW-1:0] h_re, h_im;
  logic                 h_last;
  smp_t                 mon_e;

  fft16_stage1_ctrl #(.DW(DW), .N(N), .BFLY_LAT(BFLY_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
    .bf_re_in  (bf_re_in),
    .bf_im_in  (bf_im_in),
    .bf_en     (bf_en),
    .bf_re_out (bfo_re),
    .bf_im_out (bfo_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Butterfly stand-in: identity with one enabled register stage.
  always @(posedge clk) begin
    if (bf_en) begin
      bfo_re <= bf_re_in;
      bfo_im <= bf_im_in;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          out_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
          pat_i++;
        end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference: gather samples into a frame; an in_last that disagrees with the slot
  // position drops the sample and restarts the frame. Complete frames pass through unchanged.
  function automatic void model_accept(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                                       input logic last, output logic err);
    if (last !== (mcnt == N - 1)) begin
      err  = 1'b1;
      mcnt = 0;
    end else begin
      err         = 1'b0;
      fr_re[mcnt] = re;
      fr_im[mcnt] = im;
      mcnt++;
      if (mcnt == N) begin
        for (int k = 0; k < N; k++)
          exp_q.push_back('{re: fr_re[k], im: fr_im[k], last: (k == N - 1)});
        mcnt = 0;
      end
    end
  endfunction

  task automatic send(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im, input logic last);
    int   t;
    logic err;
    t        = 0;
    in_re    = re;
    in_im    = im;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model_accept(re, im, last, err);
    chk("frame_err", frame_err, err);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int k = 0; k < N; k++)
      send(DW'(base + k), DW'(-base - 3 * k), k == N - 1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  // Scoreboard and stall-stability checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_re", out_re, h_re);
        chk("hold_im", out_im, h_im);
        chk("hold_last", out_last, h_last);
      end
      if (exp_q.size() != 0)
        chk("in_ready_while_busy", in_ready, 0);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else if (out_ready) begin
          mon_e = exp_q.pop_front();
          chk("out_re", out_re, $signed(mon_e.re));
          chk("out_im", out_im, $signed(mon_e.im));
          chk("out_last", out_last, mon_e.last);
          frame_pos = mon_e.last ? 0 : frame_pos + 1;
        end
      end
      stall_prev = out_valid && !out_ready;
      h_re       = out_re;
      h_im       = out_im;
      h_last     = out_last;
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_re    = '0;
    in_im    = '0;
    in_last  = 1'b0;

    // Reset held with traffic pending
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_bf_en", bf_en, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_busy", busy, 0);
    end
    chk("rst_out_last", out_last, 0);
    chk("rst_out_re", out_re, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Single frame re=k, im=-k, latency profile
    for (int k = 0; k < N; k++)
      send(DW'(k), DW'(-k), k == N - 1);
    chk("lat_bf_en_on", bf_en, 1);
    chk("lat_busy", busy, 1);
    chk("lat_in_ready_off", in_ready, 0);
    @(posedge clk);
    #1;
    chk("lat_bf_en_off", bf_en, 0);
    chk("lat_out_valid_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_out_valid", out_valid, 1);
    chk("lat_first_re", out_re, 0);
    wait_drain();

    // Backpressure 1-0-0-1
    rdy_mode = 1;
    pat_i    = 0;
    send_frame(100);
    wait_drain();
    rdy_mode = 0;

    // Misaligned in_last on sample 5, then a good frame
    for (int k = 0; k < 6; k++)
      send(DW'(300 + k), DW'(k), k == 5);
    @(posedge clk);
    #1;
    chk("mis_err_one_cycle", frame_err, 0);
    chk("mis_no_bf_en", bf_en, 0);
    send_frame(400);
    wait_drain();

    // Missing in_last: sixteenth sample flagged, stays loading
    for (int k = 0; k < N; k++)
      send(DW'(500 + k), DW'(-k), 1'b0);
    chk("miss_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    chk("miss_err_one_cycle", frame_err, 0);
    chk("miss_busy", busy, 0);
    chk("miss_no_bf_en", bf_en, 0);

    // Reset during drain at slot 7
    send_frame(700);
    begin
      int t;
      t = 0;
      do begin
        @(posedge clk);
        #1;
        t++;
      end while (frame_pos != 7 && t < 100);
      chk("midrst_pos7", frame_pos, 7);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    exp_q.delete();
    mcnt      = 0;
    frame_pos = 0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", in_ready, 1);
    send_frame(900);
    wait_drain();

    // Randomized frames, gaps, misalignments and output stalls
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        int p;
        p = $urandom_range(0, 14);
        for (int k = 0; k <= p; k++)
          send(DW'($urandom), DW'($urandom), k == p);
      end
      for (int k = 0; k < N; k++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send(DW'($urandom), DW'($urandom), k == N - 1);
      end
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("end_idle_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
